// File: rtl/alu_control.sv
// Registered ALU control decoder: maps ALUOP/func to an ALU operation code and
// tracks illegal R-type function codes with a sticky flag and a saturating counter.
module alu_control #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [1:0]           ALUOP,
    input  logic [5:0]           func,
    output logic [3:0]           operation,
    output logic                 out_valid,
    output logic                 illegal,
    output logic                 illegal_sticky,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BAD = 4'b1111;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [3:0]           operation_q, operation_d;
    logic                 out_valid_q, out_valid_d;
    logic                 illegal_q, illegal_d;
    logic                 illegal_sticky_q, illegal_sticky_d;
    logic [CNT_WIDTH-1:0] illegal_count_q, illegal_count_d;

    logic [3:0] dec_op;
    logic       dec_illegal;

    // func[5:4] never affects the decode
    logic unused_func_hi;
    assign unused_func_hi = ^func[5:4];

    always_comb begin
        dec_op      = OP_ADD;
        dec_illegal = 1'b0;
        case (ALUOP)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            default: begin
                case (func[3:0])
                    4'b0000: dec_op = OP_ADD;
                    4'b0010: dec_op = OP_SUB;
                    4'b0100: dec_op = OP_AND;
                    4'b0101: dec_op = OP_OR;
                    4'b0111: dec_op = OP_NOR;
                    4'b1010: dec_op = OP_SLT;
                    default: begin
                        dec_op      = OP_BAD;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

    // Idle cycles hold the last operation but drop the valid/illegal pulses
    always_comb begin
        operation_d      = in_valid ? dec_op : operation_q;
        out_valid_d      = in_valid;
        illegal_d        = in_valid & dec_illegal;
        illegal_sticky_d = illegal_sticky_q | illegal_d;
        illegal_count_d  = illegal_count_q;
        if (illegal_d && (illegal_count_q != CNT_MAX)) begin
            illegal_count_d = illegal_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            operation_q      <= 4'b0000;
            out_valid_q      <= 1'b0;
            illegal_q        <= 1'b0;
            illegal_sticky_q <= 1'b0;
            illegal_count_q  <= '0;
        end else begin
            operation_q      <= operation_d;
            out_valid_q      <= out_valid_d;
            illegal_q        <= illegal_d;
            illegal_sticky_q <= illegal_sticky_d;
            illegal_count_q  <= illegal_count_d;
        end
    end

    assign operation      = operation_q;
    assign out_valid      = out_valid_q;
    assign illegal        = illegal_q;
    assign illegal_sticky = illegal_sticky_q;
    assign illegal_count  = illegal_count_q;

endmodule

// File: tb/tb_alu_control.sv
// Directed scoreboard bench for alu_control: each step pushes the expected
// registered outputs, and the sample one cycle later pops and compares them.
module tb_alu_control;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [1:0] ALUOP;
    logic [5:0] func;
    logic [3:0] operation;
    logic       out_valid;
    logic       illegal;
    logic       illegal_sticky;
    logic [7:0] illegal_count;

    typedef struct {
        logic [3:0] op;
        logic       ov;
        logic       ill;
        logic       sticky;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_op;
    logic       m_sticky;
    logic [7:0] m_cnt;

    alu_control #(.CNT_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .ALUOP          (ALUOP),
        .func           (func),
        .operation      (operation),
        .out_valid      (out_valid),
        .illegal        (illegal),
        .illegal_sticky (illegal_sticky),
        .illegal_count  (illegal_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode, written straight from the operation table
    function automatic logic [4:0] refDecode(input logic [1:0] a, input logic [5:0] f);
        if (a == 2'b00) return {1'b0, 4'b0010};
        if (a == 2'b01) return {1'b0, 4'b0110};
        case (f[3:0])
            4'd0:    return {1'b0, 4'b0010};
            4'd2:    return {1'b0, 4'b0110};
            4'd4:    return {1'b0, 4'b0000};
            4'd5:    return {1'b0, 4'b0001};
            4'd7:    return {1'b0, 4'b1100};
            4'd10:   return {1'b0, 4'b0111};
            default: return {1'b1, 4'b1111};
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        assert (actual === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] a, input logic [5:0] f);
        exp_t e;
        logic [4:0] d;
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        ALUOP    = a;
        func     = f;
        if (rst) begin
            m_op     = 4'b0000;
            m_sticky = 1'b0;
            m_cnt    = 8'd0;
            e = '{op: 4'b0000, ov: 1'b0, ill: 1'b0, sticky: 1'b0, cnt: 8'd0};
        end else begin
            d = refDecode(a, f);
            if (v) m_op = d[3:0];
            if (v && d[4]) begin
                m_sticky = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
            e = '{op: m_op, ov: v, ill: v & d[4], sticky: m_sticky, cnt: m_cnt};
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        checks++;
        assert (exp_q.size() > 0)
        else begin
            failures++;
            $error("[TB] FAIL %s_queue: observed=empty expected=entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_op"},     {4'b0, operation},   {4'b0, e.op});
        check({tag, "_valid"},  {7'b0, out_valid},   {7'b0, e.ov});
        check({tag, "_illegal"},{7'b0, illegal},     {7'b0, e.ill});
        check({tag, "_sticky"}, {7'b0, illegal_sticky}, {7'b0, e.sticky});
        check({tag, "_count"},  illegal_count,       e.cnt);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        ALUOP    = 2'b00;
        func     = 6'd0;
        m_op     = 4'b0000;
        m_sticky = 1'b0;
        m_cnt    = 8'd0;

        applyStimulus(1'b1, 1'b0, 2'b00, 6'd0);   checkOutput("reset");
        applyStimulus(1'b0, 1'b1, 2'b00, 6'd0);   checkOutput("ldst");
        applyStimulus(1'b0, 1'b1, 2'b00, 6'h3F);  checkOutput("ldst_func");
        applyStimulus(1'b0, 1'b1, 2'b01, 6'd0);   checkOutput("branch");

        // R-type sweep with ALUOP=10
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd0);   checkOutput("r_add");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd2);   checkOutput("r_sub");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd4);   checkOutput("r_and");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd5);   checkOutput("r_or");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd7);   checkOutput("r_nor");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd10);  checkOutput("r_slt");

        applyStimulus(1'b0, 1'b1, 2'b11, 6'd2);   checkOutput("r11_sub");
        applyStimulus(1'b0, 1'b1, 2'b11, 6'd10);  checkOutput("r11_slt");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'h22);  checkOutput("r_hibits");
        applyStimulus(1'b0, 1'b0, 2'b10, 6'd4);   checkOutput("idle_hold");

        applyStimulus(1'b0, 1'b1, 2'b10, 6'd3);   checkOutput("illegal");
        applyStimulus(1'b0, 1'b0, 2'b00, 6'd0);   checkOutput("illegal_idle");
        applyStimulus(1'b0, 1'b1, 2'b01, 6'd3);   checkOutput("legal_after");

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 2'b11, (i % 2 == 0) ? 6'd15 : 6'h38);
            checkOutput("sat");
        end
        check("sat_final", illegal_count, 8'd255);

        applyStimulus(1'b1, 1'b1, 2'b10, 6'd3);   checkOutput("reset_drop");
        applyStimulus(1'b0, 1'b1, 2'b10, 6'd7);   checkOutput("first_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
